// File: rtl/cnn_pkg.sv
// Shared types and image geometry for the CNN front end (window generator and line buffers).
package cnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int K     = 5;
  localparam int DW    = 8;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef logic signed [DW-1:0] pixel_t;
  typedef logic [COL_W-1:0]     col_t;
  typedef logic [ROW_W-1:0]     row_t;

  typedef enum logic {FILL, RUN} lb_state_t;

  // Raster positions that matter to the window generator.
  localparam col_t LAST_COL      = col_t'(IMG_W - 1);
  localparam row_t LAST_ROW      = row_t'(IMG_H - 1);
  localparam col_t WIN_MIN_COL   = col_t'(K - 1);
  localparam row_t FILL_LAST_ROW = row_t'(K - 2);

endpackage

// File: rtl/linebuf_row.sv
// One image row of delay: circular RAM read and written at the same column pointer.
module linebuf_row
  import cnn_pkg::*;
(
  input  logic   clk,
  input  logic   wr_en,
  input  col_t   ptr,
  input  pixel_t din,
  output pixel_t dout
);

  pixel_t mem [IMG_W];

  // Read returns the pixel stored one row ago at this column, before it is overwritten.
  assign dout = mem[ptr];

  // NOTE: storage RAM carries no reset; every entry is rewritten before it can feed a valid window.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr] <= din;
  end

endmodule

// File: rtl/conv_window_linebuf.sv
// Streaming 5x5 sliding-window generator over a raster 28x28 image.
// Optional: define LINEBUF_OVERRUN_CHK_EN to add the sticky overrun_err output.
module conv_window_linebuf
  import cnn_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  pixel_t pixel_in,
  input  logic   pixel_valid,
  input  logic   frame_start,
  output pixel_t data_out_0,  output pixel_t data_out_1,  output pixel_t data_out_2,
  output pixel_t data_out_3,  output pixel_t data_out_4,  output pixel_t data_out_5,
  output pixel_t data_out_6,  output pixel_t data_out_7,  output pixel_t data_out_8,
  output pixel_t data_out_9,  output pixel_t data_out_10, output pixel_t data_out_11,
  output pixel_t data_out_12, output pixel_t data_out_13, output pixel_t data_out_14,
  output pixel_t data_out_15, output pixel_t data_out_16, output pixel_t data_out_17,
  output pixel_t data_out_18, output pixel_t data_out_19, output pixel_t data_out_20,
  output pixel_t data_out_21, output pixel_t data_out_22, output pixel_t data_out_23,
  output pixel_t data_out_24,
  output logic   valid_out_buf,
`ifdef LINEBUF_OVERRUN_CHK_EN
  output logic   overrun_err,
`endif
  output logic   frame_done
);

  row_t      row_q, cur_row;
  col_t      col_q, cur_col;
  lb_state_t state_q, state_d;
  logic      restart, last_pix, win_hit;
  pixel_t    lb_in  [K-1];
  pixel_t    lb_out [K-1];
  pixel_t    new_col[K];
  pixel_t    win_q  [K*K];

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    restart  = pixel_valid && frame_start;
    cur_row  = restart ? '0 : row_q;
    cur_col  = restart ? '0 : col_q;
    last_pix = pixel_valid && !frame_start && (row_q == LAST_ROW) && (col_q == LAST_COL);
    win_hit  = pixel_valid && !frame_start && (state_q == RUN) && (col_q >= WIN_MIN_COL);

    state_d = state_q;
    if (restart) begin
      state_d = FILL;
    end else if (pixel_valid) begin
      if (last_pix)                                          state_d = FILL;
      else if (row_q == FILL_LAST_ROW && col_q == LAST_COL)  state_d = RUN;
    end

    new_col[K-1] = pixel_in;
    for (int r = 0; r < K-1; r++) new_col[r] = lb_out[K-2-r];
  end

  // Line buffer i delays by i+1 rows; a resync rewrites from column 0.
  assign lb_in[0] = pixel_in;
  for (genvar i = 1; i < K-1; i++) begin : g_chain
    assign lb_in[i] = lb_out[i-1];
  end

  for (genvar i = 0; i < K-1; i++) begin : g_lb
    linebuf_row u_row (
      .clk   (clk),
      .wr_en (pixel_valid),
      .ptr   (cur_col),
      .din   (lb_in[i]),
      .dout  (lb_out[i])
    );
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q         <= '0;
      col_q         <= '0;
      state_q       <= FILL;
      valid_out_buf <= 1'b0;
      frame_done    <= 1'b0;
      for (int i = 0; i < K*K; i++) win_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      valid_out_buf <= win_hit;
      frame_done    <= last_pix;
      if (pixel_valid) begin
        if (cur_col == LAST_COL) begin
          col_q <= '0;
          row_q <= (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
        end else begin
          col_q <= cur_col + 1'b1;
          row_q <= cur_row;
        end
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) win_q[r*K+c] <= win_q[r*K+c+1];
          win_q[r*K+K-1] <= new_col[r];
        end
      end
    end
  end

`ifdef LINEBUF_OVERRUN_CHK_EN
  // Sticky: a pixel pushed into a finished frame, or a resync landing mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_err <= 1'b0;
    end else if ((pixel_valid && !frame_start && frame_done) ||
                 (restart && (row_q != '0 || col_q != '0))) begin
      overrun_err <= 1'b1;
    end
  end
`else
  // No overrun tracking in this build.
`endif

  assign data_out_0  = win_q[0];   assign data_out_1  = win_q[1];   assign data_out_2  = win_q[2];
  assign data_out_3  = win_q[3];   assign data_out_4  = win_q[4];   assign data_out_5  = win_q[5];
  assign data_out_6  = win_q[6];   assign data_out_7  = win_q[7];   assign data_out_8  = win_q[8];
  assign data_out_9  = win_q[9];   assign data_out_10 = win_q[10];  assign data_out_11 = win_q[11];
  assign data_out_12 = win_q[12];  assign data_out_13 = win_q[13];  assign data_out_14 = win_q[14];
  assign data_out_15 = win_q[15];  assign data_out_16 = win_q[16];  assign data_out_17 = win_q[17];
  assign data_out_18 = win_q[18];  assign data_out_19 = win_q[19];  assign data_out_20 = win_q[20];
  assign data_out_21 = win_q[21];  assign data_out_22 = win_q[22];  assign data_out_23 = win_q[23];
  assign data_out_24 = win_q[24];

endmodule

// File: tb/tb_conv_window_linebuf.sv
// Self-checking bench: random/ramp frames against an image-array reference model.
// Exercises LINEBUF_OVERRUN_CHK_EN when that macro is defined for the build.
module tb_conv_window_linebuf;
  import cnn_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  pixel_t pixel_in;
  logic   pixel_valid, frame_start;
  pixel_t dout [25];
  logic   valid_out_buf, frame_done;
`ifdef LINEBUF_OVERRUN_CHK_EN
  logic   overrun_err;
`endif

  always #5 clk = ~clk;

  conv_window_linebuf dut (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .data_out_0(dout[0]),   .data_out_1(dout[1]),   .data_out_2(dout[2]),   .data_out_3(dout[3]),
    .data_out_4(dout[4]),   .data_out_5(dout[5]),   .data_out_6(dout[6]),   .data_out_7(dout[7]),
    .data_out_8(dout[8]),   .data_out_9(dout[9]),   .data_out_10(dout[10]), .data_out_11(dout[11]),
    .data_out_12(dout[12]), .data_out_13(dout[13]), .data_out_14(dout[14]), .data_out_15(dout[15]),
    .data_out_16(dout[16]), .data_out_17(dout[17]), .data_out_18(dout[18]), .data_out_19(dout[19]),
    .data_out_20(dout[20]), .data_out_21(dout[21]), .data_out_22(dout[22]), .data_out_23(dout[23]),
    .data_out_24(dout[24]),
    .valid_out_buf(valid_out_buf),
`ifdef LINEBUF_OVERRUN_CHK_EN
    .overrun_err(overrun_err),
`endif
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the image as written so far, plus the raster position of the next pixel.
  int            img [IMG_H][IMG_W];
  int            m_r, m_c;
  logic [199:0]  hold_taps;
  bit            hold_known;
  int            n_valid, n_done;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [199:0] taps();
    logic [199:0] v;
    for (int i = 0; i < 25; i++) v[i*8 +: 8] = dout[i];
    return v;
  endfunction

  task automatic model_reset();
    m_r = 0; m_c = 0;
    hold_taps = '0; hold_known = 1'b1;
  endtask

  task automatic accept(input pixel_t p, input bit fs);
    logic [199:0] exp_taps;
    bit           exp_v, exp_d;
    exp_taps = '0;
    pixel_valid = 1'b1; pixel_in = p; frame_start = fs;
    if (fs) begin m_r = 0; m_c = 0; end
    img[m_r][m_c] = int'(p);
    exp_v = (m_r >= K-1) && (m_c >= K-1);
    exp_d = (m_r == IMG_H-1) && (m_c == IMG_W-1);
    if (exp_v)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          exp_taps[(i*K+j)*8 +: 8] = 8'(img[m_r-(K-1)+i][m_c-(K-1)+j]);
    if (m_c == IMG_W-1) begin m_c = 0; m_r = (m_r == IMG_H-1) ? 0 : m_r + 1; end
    else m_c++;
    @(posedge clk); #1;
    pixel_valid = 1'b0; frame_start = 1'b0;
    check("valid_out_buf", valid_out_buf, exp_v);
    check("frame_done", frame_done, exp_d);
    if (valid_out_buf) n_valid++;
    if (frame_done)    n_done++;
    if (exp_v) begin
      check("window_taps", taps(), exp_taps);
      hold_taps = exp_taps; hold_known = 1'b1;
    end else begin
      hold_known = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      check("gap_valid", valid_out_buf, 1'b0);
      check("gap_frame_done", frame_done, 1'b0);
      if (frame_done) n_done++;
      if (hold_known) check("gap_taps_hold", taps(), hold_taps);
    end
  endtask

  // Sends raster indices [from, to]; index 0 carries frame_start. Ramp gives pix(r,c)=(r*28+c)%128.
  task automatic send_range(input int from, input int to, input bit ramp, input int gap_max);
    pixel_t p;
    for (int i = from; i <= to; i++) begin
      p = ramp ? pixel_t'(i % 128) : pixel_t'($urandom);
      accept(p, i == 0);
      if (gap_max > 0) idle($urandom_range(gap_max, 0));
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_done = 0;
  endtask

  localparam int LAST_IDX = IMG_W*IMG_H - 1;

  initial begin
    rst = 1'b1; pixel_in = '0; pixel_valid = 1'b0; frame_start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid_out_buf, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_taps", taps(), '0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, continuous valid: first window and frame totals.
    clear_counts();
    send_range(0, 4*IMG_W + 4, 1'b1, 0);
    check("first_win_tap0",  dout[0],  8'd0);
    check("first_win_tap4",  dout[4],  8'd4);
    check("first_win_tap20", dout[20], 8'd112);
    check("first_win_tap24", dout[24], 8'd116);
    send_range(4*IMG_W + 5, LAST_IDX, 1'b1, 0);
    idle(2);
    check("ramp_window_count", n_valid, 576);
    check("ramp_frame_done_count", n_done, 1);

    // Same ramp frame with random gaps.
    clear_counts();
    send_range(0, LAST_IDX, 1'b1, 3);
    idle(2);
    check("gap_window_count", n_valid, 576);
    check("gap_frame_done_count", n_done, 1);

    // Random frame resynchronised at (10,7); the new frame is counted from the resync.
    send_range(0, 10*IMG_W + 7 - 1, 1'b0, 2);
    clear_counts();
    accept(pixel_t'($urandom), 1'b1);
    send_range(1, LAST_IDX, 1'b0, 2);
    idle(1);
    check("resync_window_count", n_valid, 576);
    check("resync_frame_done_count", n_done, 1);

    // Last pixel coinciding with frame_start: it becomes (0,0), no frame_done.
    send_range(0, LAST_IDX - 1, 1'b0, 1);
    clear_counts();
    accept(pixel_t'($urandom), 1'b1);
    check("fs_on_last_no_done", n_done, 0);
    send_range(1, LAST_IDX, 1'b0, 0);
    idle(1);
    check("fs_on_last_window_count", n_valid, 576);
    check("fs_on_last_done_count", n_done, 1);

    // Asynchronous reset mid-frame at (15,15), then a full clean frame.
    send_range(0, 15*IMG_W + 15, 1'b1, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", valid_out_buf, 1'b0);
    check("async_rst_frame_done", frame_done, 1'b0);
    check("async_rst_taps", taps(), '0);
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    clear_counts();
    for (int i = 0; i <= LAST_IDX; i++) accept(pixel_t'(i % 128), 1'b0);
    idle(2);
    check("post_rst_window_count", n_valid, 576);
    check("post_rst_frame_done_count", n_done, 1);

`ifdef LINEBUF_OVERRUN_CHK_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    #1;
    check("overrun_after_rst", overrun_err, 1'b0);
    send_range(0, LAST_IDX, 1'b1, 0);
    send_range(0, 3*IMG_W + 8, 1'b1, 0);
    check("overrun_clean_frames", overrun_err, 1'b0);
    accept(pixel_t'(0), 1'b1);
    check("overrun_set_midframe_fs", overrun_err, 1'b1);
    send_range(1, LAST_IDX, 1'b1, 0);
    idle(1);
    send_range(0, LAST_IDX, 1'b1, 1);
    idle(1);
    check("overrun_sticky", overrun_err, 1'b1);
    @(negedge clk); rst = 1'b1;
    #1;
    check("overrun_cleared_by_rst", overrun_err, 1'b0);
    @(negedge clk); rst = 1'b0;
    model_reset();
    send_range(0, LAST_IDX, 1'b1, 0);
    accept(pixel_t'(0), 1'b0);
    check("overrun_set_during_done", overrun_err, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
